// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, watchdog sizing and FSM encoding
// for the AES core arbiter.
package aes_pkg;

   localparam int AES_KEY_W       = 128;
   localparam int AES_BLK_W       = 128;
   localparam int AES_WD_W        = 8;
   localparam int AES_TIMEOUT_DEF = 255;
   localparam int AES_KEY_BLANK   = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY_LOAD,
      S_KEY_WAIT,
      S_START,
      S_WAIT_CLR,
      S_WAIT_DONE,
      S_RESP
   } aes_arb_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: combinational round-robin pick, searching
// upward from last_i+1 modulo N.
module aes_rr_arbiter #(
   parameter int  N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   localparam logic [IW:0] NUM = (IW+1)'(N);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot;
   logic [IW:0]    sh;
   logic [IW:0]    off;
   logic [IW:0]    sum;
   logic           found;

   // Rotate a doubled request vector so bit 0 is the
   // first candidate after the previous winner.
   always_comb begin
      dbl   = {req_i, req_i};
      sh    = {1'b0, last_i} + {{IW{1'b0}}, 1'b1};
      rot   = dbl >> sh;
      off   = '0;
      found = 1'b0;
      for (int p = 0; p < N; p++) begin
         if (!found && rot[p]) begin
            found = 1'b1;
            off   = p[IW:0];
         end
      end
      sum = sh + off;
      if (sum >= NUM) begin
         sum = sum - NUM;
      end
   end

   always_comb begin
      any_o = found;
      idx_o = sum[IW-1:0];
      gnt_o = '0;
      for (int i = 0; i < N; i++) begin
         gnt_o[i] = found && (sum[IW-1:0] == i[IW-1:0]);
      end
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES-128 core among NUM_REQ clients.
// Key reuse across jobs is enabled by defining AES_ARB_KEY_CACHE_EN.
module aes_core_arbiter
   import aes_pkg::*;
#(
   parameter int  NUM_REQ        = 4,
   parameter int  TIMEOUT_CYCLES = AES_TIMEOUT_DEF,
   localparam int IW             = $clog2(NUM_REQ)
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*AES_KEY_W-1:0] req_key,
   input  logic [NUM_REQ*AES_BLK_W-1:0] req_block,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [IW-1:0]                rsp_id,
   output logic [AES_BLK_W-1:0]         rsp_block,
   output logic                         rsp_err,
   output logic [AES_KEY_W-1:0]         core_key,
   output logic                         core_keylen,
   output logic                         core_key_init,
   input  logic                         core_key_ready,
   output logic                         core_next,
   output logic [AES_BLK_W-1:0]         core_input_block,
   input  logic [AES_BLK_W-1:0]         core_output_block,
   input  logic                         core_block_ready
);

   localparam logic [AES_WD_W-1:0] TO    = AES_WD_W'(TIMEOUT_CYCLES);
   localparam logic [AES_WD_W-1:0] BLANK = AES_WD_W'(AES_KEY_BLANK);

   aes_arb_state_t state_q, state_d;

   logic [IW-1:0]        last_q, last_d;
   logic [IW-1:0]        id_q, id_d;
   logic [IW-1:0]        rid_q, rid_d;
   logic [AES_KEY_W-1:0] key_q, key_d;
   logic [AES_BLK_W-1:0] blk_q, blk_d;
   logic [AES_BLK_W-1:0] rblk_q, rblk_d;
   logic                 rerr_q, rerr_d;
   logic [AES_WD_W-1:0]  wd_q, wd_d;
   logic [AES_WD_W-1:0]  wd_inc;
   logic                 wd_hit;

   logic [AES_KEY_W-1:0] keys [NUM_REQ];
   logic [AES_BLK_W-1:0] blks [NUM_REQ];
   logic [NUM_REQ-1:0]   win_gnt;
   logic [IW-1:0]        win_idx;
   logic                 win_any;
   logic [AES_KEY_W-1:0] win_key;
   logic [AES_BLK_W-1:0] win_blk;
   logic                 hit;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign keys[g] = req_key[AES_KEY_W*g +: AES_KEY_W];
      assign blks[g] = req_block[AES_BLK_W*g +: AES_BLK_W];
   end

   aes_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req_i  (req_valid),
      .last_i (last_q),
      .gnt_o  (win_gnt),
      .idx_o  (win_idx),
      .any_o  (win_any)
   );

   assign win_key = keys[win_idx];
   assign win_blk = blks[win_idx];

`ifdef AES_ARB_KEY_CACHE_EN
   logic kv_q, kv_d;
   // key_q always holds the last key handed to the core.
   assign hit = kv_q && (win_key == key_q);
`else
   assign hit = 1'b0;
`endif

   assign wd_inc = wd_q + 1'b1;
   assign wd_hit = (wd_inc == TO);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      rid_d   = rid_q;
      key_d   = key_q;
      blk_d   = blk_q;
      rblk_d  = rblk_q;
      rerr_d  = rerr_q;
      wd_d    = wd_q;
`ifdef AES_ARB_KEY_CACHE_EN
      kv_d    = kv_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (win_any) begin
               last_d = win_idx;
               id_d   = win_idx;
               blk_d  = win_blk;
               if (hit) begin
                  state_d = S_START;
               end else begin
                  key_d   = win_key;
                  state_d = S_KEY_LOAD;
               end
            end
         end
         S_KEY_LOAD: begin
            wd_d    = '0;
            state_d = S_KEY_WAIT;
         end
         S_KEY_WAIT: begin
            wd_d = wd_inc;
            if (wd_hit) begin
               state_d = S_RESP;
               rerr_d  = 1'b1;
               rblk_d  = '0;
               rid_d   = id_q;
`ifdef AES_ARB_KEY_CACHE_EN
               kv_d    = 1'b0;
`endif
            end else if (wd_q >= BLANK && core_key_ready) begin
               state_d = S_START;
`ifdef AES_ARB_KEY_CACHE_EN
               kv_d    = 1'b1;
`endif
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT_CLR;
         end
         S_WAIT_CLR: begin
            wd_d = wd_inc;
            if (wd_hit) begin
               state_d = S_RESP;
               rerr_d  = 1'b1;
               rblk_d  = '0;
               rid_d   = id_q;
`ifdef AES_ARB_KEY_CACHE_EN
               kv_d    = 1'b0;
`endif
            end else if (!core_block_ready) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            wd_d = wd_inc;
            if (core_block_ready) begin
               state_d = S_RESP;
               rerr_d  = 1'b0;
               rblk_d  = core_output_block;
               rid_d   = id_q;
            end else if (wd_hit) begin
               state_d = S_RESP;
               rerr_d  = 1'b1;
               rblk_d  = '0;
               rid_d   = id_q;
`ifdef AES_ARB_KEY_CACHE_EN
               kv_d    = 1'b0;
`endif
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         id_q    <= '0;
         rid_q   <= '0;
         key_q   <= '0;
         blk_q   <= '0;
         rblk_q  <= '0;
         rerr_q  <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         rid_q   <= rid_d;
         key_q   <= key_d;
         blk_q   <= blk_d;
         rblk_q  <= rblk_d;
         rerr_q  <= rerr_d;
         wd_q    <= wd_d;
      end
   end

`ifdef AES_ARB_KEY_CACHE_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         kv_q <= 1'b0;
      end else begin
         kv_q <= kv_d;
      end
   end
`endif

   assign req_ready        = (state_q == S_IDLE) ? win_gnt : '0;
   assign rsp_valid        = (state_q == S_RESP);
   assign rsp_id           = rid_q;
   assign rsp_block        = rblk_q;
   assign rsp_err          = rerr_q;
   assign core_key         = key_q;
   assign core_keylen      = 1'b0;
   assign core_key_init    = (state_q == S_KEY_LOAD);
   assign core_next        = (state_q == S_START);
   assign core_input_block = blk_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: random and directed jobs against a
// behavioural round-robin/cache model and a stub AES core.
module tb_aes_core_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int TO = 16;

   logic               aclk = 1'b0;
   logic               aresetn = 1'b0;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [127:0]       kkey [N];
   logic [127:0]       kblk [N];
   logic [N*128-1:0]   req_key;
   logic [N*128-1:0]   req_block;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   logic [127:0]       rsp_block;
   logic               rsp_err;
   logic [127:0]       core_key;
   logic               core_keylen;
   logic               core_key_init;
   logic               core_key_ready;
   logic               core_next;
   logic [127:0]       core_input_block;
   logic [127:0]       core_output_block;
   logic               core_block_ready;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_key[128*g +: 128]   = kkey[g];
      assign req_block[128*g +: 128] = kblk[g];
   end

   aes_core_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_key           (req_key),
      .req_block         (req_block),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_id            (rsp_id),
      .rsp_block         (rsp_block),
      .rsp_err           (rsp_err),
      .core_key          (core_key),
      .core_keylen       (core_keylen),
      .core_key_init     (core_key_init),
      .core_key_ready    (core_key_ready),
      .core_next         (core_next),
      .core_input_block  (core_input_block),
      .core_output_block (core_output_block),
      .core_block_ready  (core_block_ready)
   );

   initial forever #5 aclk = ~aclk;

   localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // Stand-in cipher: exact for the FIPS-197 vector, a keyed mix otherwise.
   function automatic logic [127:0] core_fn(input logic [127:0] k,
                                            input logic [127:0] b);
      if (k == FIPS_K && b == FIPS_P) return FIPS_C;
      return (b ^ {k[95:0], k[127:96]}) +
             128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   // ---- stub AES core ----
   logic [127:0] s_key, s_blk;
   int           kcnt, bcnt;
   bit           stub_hang;
   int           blk_lat_fix;
   int           seen_loads;
   int           cyc;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         core_key_ready    <= 1'b0;
         core_block_ready  <= 1'b0;
         core_output_block <= '0;
         s_key             <= '0;
         s_blk             <= '0;
         kcnt              <= 0;
         bcnt              <= 0;
      end else begin
         if (core_key_init) begin
            s_key          <= core_key;
            core_key_ready <= 1'b0;
            kcnt           <= $urandom_range(1, 5);
         end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_key_ready <= 1'b1;
         end
         if (core_next) begin
            s_blk            <= core_input_block;
            core_block_ready <= 1'b0;
            bcnt <= stub_hang ? 0 :
                    (blk_lat_fix != 0 ? blk_lat_fix : $urandom_range(1, 6));
         end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
               core_block_ready  <= 1'b1;
               core_output_block <= core_fn(s_key, s_blk);
            end
         end
      end
   end

   initial seen_loads = 0;
   always @(posedge aclk) if (core_key_init) seen_loads <= seen_loads + 1;
   initial cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // ---- checking ----
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---- behavioural model ----
   int           m_last;
   bit           m_busy;
   int           m_id;
   logic [127:0] m_exp_blk;
   bit           m_exp_err;
   bit           m_cv;
   logic [127:0] m_ck;
   int           exp_loads = 0;
   int           acc_id;
   int           rsp_ids [$];
   bit           rsp_seen;
   int           rsp_cyc;
   logic [127:0] rsp_blk_s;
   logic         rsp_err_s;
   int           rsp_id_s;
   int           next_cyc;
   int           next_cnt = 0;

   function automatic int model_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      int           w;
      logic [N-1:0] er;
      bit           hs_req, hs_rsp, hit;
      logic [127:0] k, b;
      acc_id = -1;
      #1;
      w  = model_pick(req_valid, m_last);
      er = '0;
      if (!m_busy && w >= 0) er[w] = 1'b1;
      check("req_ready", 128'(req_ready), 128'(er));
      hs_req = (er != '0);
      hs_rsp = 1'b0;
      if (hs_req) begin
         k = kkey[w];
         b = kblk[w];
      end
      if (core_next) begin
         next_cyc = cyc;
         next_cnt++;
      end
      if (!m_busy) begin
         check("rsp_valid_idle", 128'(rsp_valid), 128'(0));
         check("next_idle", 128'(core_next), 128'(0));
      end else if (rsp_valid) begin
         if (!rsp_seen) begin
            rsp_seen  = 1'b1;
            rsp_cyc   = cyc;
            rsp_blk_s = rsp_block;
            rsp_err_s = rsp_err;
            rsp_id_s  = int'(rsp_id);
         end
         check("rsp_id", 128'(rsp_id), 128'(m_id));
         check("rsp_block", rsp_block, m_exp_blk);
         check("rsp_err", 128'(rsp_err), 128'(m_exp_err));
         hs_rsp = rsp_ready;
      end
      @(posedge aclk);
      if (hs_rsp) begin
         m_busy   = 1'b0;
         rsp_seen = 1'b0;
         rsp_ids.push_back(m_id);
         if (m_exp_err) m_cv = 1'b0;
      end
      if (hs_req) begin
`ifdef AES_ARB_KEY_CACHE_EN
         hit = m_cv && (k == m_ck);
`else
         hit = 1'b0;
`endif
         if (!hit) begin
            exp_loads++;
            m_ck = k;
            m_cv = 1'b1;
         end
         m_busy    = 1'b1;
         m_last    = w;
         m_id      = w;
         m_exp_err = stub_hang;
         m_exp_blk = stub_hang ? '0 : core_fn(k, b);
         acc_id    = w;
      end
      @(negedge aclk);
   endtask

   task automatic model_reset();
      m_last   = N - 1;
      m_busy   = 1'b0;
      m_cv     = 1'b0;
      rsp_seen = 1'b0;
   endtask

   task automatic do_reset();
      aresetn     = 1'b0;
      req_valid   = '0;
      rsp_ready   = 1'b1;
      stub_hang   = 1'b0;
      blk_lat_fix = 0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      model_reset();
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (m_busy && n < bound) begin
         step();
         n++;
      end
      check("drain", 128'(m_busy), 128'(0));
   endtask

   task automatic do_job(input int i, input logic [127:0] k,
                         input logic [127:0] b);
      int n = 0;
      kkey[i]      = k;
      kblk[i]      = b;
      req_valid[i] = 1'b1;
      step();
      while (acc_id != i && n < 20) begin
         step();
         n++;
      end
      check("job_accept", 128'(acc_id == i), 128'(1));
      req_valid[i] = 1'b0;
      drain(100);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int           n, l0;
      logic [127:0] kc, pool [2];
      int           seq [5];
      seq = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) begin
         kkey[i] = '0;
         kblk[i] = '0;
      end
      req_valid   = '0;
      rsp_ready   = 1'b1;
      stub_hang   = 1'b0;
      blk_lat_fix = 0;
      model_reset();
      repeat (2) @(negedge aclk);
      #1;
      check("rst_req_ready", 128'(req_ready), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_rsp_id", 128'(rsp_id), 128'(0));
      check("rst_rsp_block", rsp_block, 128'(0));
      check("rst_rsp_err", 128'(rsp_err), 128'(0));
      check("rst_core_key", core_key, 128'(0));
      check("rst_key_init", 128'(core_key_init), 128'(0));
      check("rst_next", 128'(core_next), 128'(0));
      check("rst_input_block", core_input_block, 128'(0));
      check("keylen", 128'(core_keylen), 128'(0));
      @(negedge aclk);
      aresetn = 1'b1;

      // FIPS-197 single job on requester 0
      do_job(0, FIPS_K, FIPS_P);
      check("fips_block", rsp_blk_s, FIPS_C);
      check("fips_id", 128'(rsp_id_s), 128'(0));
      check("fips_err", 128'(rsp_err_s), 128'(0));

      // all requesters held valid: round-robin order
      do_reset();
      rsp_ids.delete();
      for (int i = 0; i < N; i++) kkey[i] = rnd128();
      req_valid = '1;
      n = 0;
      while (rsp_ids.size() < 5 && n < 400) begin
         step();
         if (acc_id >= 0) kkey[acc_id] = rnd128();
         n++;
      end
      req_valid = '0;
      drain(100);
      check("rr_count", 128'(rsp_ids.size() >= 5), 128'(1));
      for (int i = 0; i < 5 && i < rsp_ids.size(); i++) begin
         check($sformatf("rr_seq%0d", i), 128'(rsp_ids[i]), 128'(seq[i]));
      end

      // response back-pressure
      do_reset();
      rsp_ready = 1'b0;
      kkey[2]   = rnd128();
      kblk[2]   = rnd128();
      req_valid = 4'b0100;
      step();
      req_valid = 4'b1011;
      n = 0;
      while (!rsp_seen && n < 100) begin
         step();
         n++;
      end
      check("stall_rsp_seen", 128'(rsp_seen), 128'(1));
      l0 = next_cnt;
      for (int c = 0; c < 20; c++) begin
         #1;
         check("stall_valid", 128'(rsp_valid), 128'(1));
         check("stall_block", rsp_block, rsp_blk_s);
         check("stall_ready", 128'(req_ready), 128'(0));
         check("stall_next", 128'(core_next), 128'(0));
         step();
      end
      check("stall_next_cnt", 128'(next_cnt - l0), 128'(0));
      req_valid = '0;
      rsp_ready = 1'b1;
      drain(50);

      // two jobs sharing one key
      do_reset();
      kc = rnd128();
      l0 = seen_loads;
      do_job(1, kc, rnd128());
      do_job(1, kc, rnd128());
`ifdef AES_ARB_KEY_CACHE_EN
      check("cache_loads", 128'(seen_loads - l0), 128'(1));
`else
      check("cache_loads", 128'(seen_loads - l0), 128'(2));
`endif

      // watchdog on a core that never completes
      do_reset();
      stub_hang = 1'b1;
      kc = rnd128();
      do_job(2, kc, rnd128());
      check("to_latency", 128'(rsp_cyc - next_cyc), 128'(17));
      check("to_err", 128'(rsp_err_s), 128'(1));
      check("to_block", rsp_blk_s, 128'(0));
      stub_hang = 1'b0;
      l0 = seen_loads;
      do_job(2, kc, rnd128());
      check("to_reload", 128'(seen_loads - l0), 128'(1));

      // asynchronous reset during WAIT_DONE
      do_reset();
      do_job(3, rnd128(), rnd128());
      blk_lat_fix  = 10;
      kkey[1]      = rnd128();
      kblk[1]      = rnd128();
      req_valid[1] = 1'b1;
      l0 = next_cnt;
      step();
      req_valid = '0;
      n = 0;
      while (next_cnt == l0 && n < 30) begin
         step();
         n++;
      end
      repeat (3) step();
      #2 aresetn = 1'b0;
      #1;
      check("mid_req_ready", 128'(req_ready), 128'(0));
      check("mid_rsp_valid", 128'(rsp_valid), 128'(0));
      check("mid_rsp_id", 128'(rsp_id), 128'(0));
      check("mid_rsp_block", rsp_block, 128'(0));
      check("mid_rsp_err", 128'(rsp_err), 128'(0));
      check("mid_core_key", core_key, 128'(0));
      check("mid_key_init", 128'(core_key_init), 128'(0));
      check("mid_next", 128'(core_next), 128'(0));
      check("mid_input_block", core_input_block, 128'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      model_reset();
      blk_lat_fix = 0;
      req_valid   = 4'b1011;
      #1;
      check("mid_first_grant", 128'(req_ready), 128'(4'b0001));
      step();
      req_valid = '0;
      drain(100);

      // randomized traffic
      pool[0] = rnd128();
      pool[1] = rnd128();
      rsp_ids.delete();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (acc_id == i) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req_valid[i] = 1'b1;
               kkey[i] = ($urandom_range(0, 2) == 2) ? rnd128()
                                                   : pool[$urandom_range(0, 1)];
               kblk[i] = rnd128();
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      drain(100);
      check("rand_jobs", 128'(rsp_ids.size() > 20), 128'(1));
      check("key_loads", 128'(seen_loads), 128'(exp_loads));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Round-robin controller that shares one `aes_encryption` core between `NUM_REQ` requesters. It accepts one (key, plaintext) job at a time, loads the key into the core when needed, starts the block, and waits for completion. It then returns the ciphertext tagged with the requester index. It sits between the client DMA/stream front-ends and the single AES-128 datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 255: watchdog limit per key load and per block; 8-bit counter.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: job request per requester.
- `req_ready` out NUM_REQ: one-hot accept; job transfers on valid&ready.
- `req_key` in NUM_REQ*128: per-requester key; slice i = [128*i +: 128].
- `req_block` in NUM_REQ*128: per-requester plaintext.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out clog2(NUM_REQ): requester index of result.
- `rsp_block` out 128: ciphertext.
- `rsp_err` out 1: job aborted by watchdog; `rsp_block` = 0.
- `core_key` out 128: key to core, held stable from KEY_LOAD until the next key load.
- `core_keylen` out 1: constant 0 (AES-128).
- `core_key_init` out 1: one-cycle key-expansion pulse.
- `core_key_ready` in 1: key schedule valid.
- `core_next` out 1: one-cycle block start pulse.
- `core_input_block` out 128: plaintext, held from START through WAIT_DONE.
- `core_output_block` in 128: ciphertext.
- `core_block_ready` in 1: core done flag (level, cleared by core after `next`).

## Operation
- FSM: IDLE, KEY_LOAD, KEY_WAIT, START, WAIT_CLR, WAIT_DONE, RESP.
- IDLE: winner = first asserted `req_valid` searching from `last_grant+1` modulo NUM_REQ. `req_ready` is one-hot on the winner, combinational, and only in IDLE with no pending response. On transfer, capture key, block and id, then update `last_grant`. Next state is KEY_LOAD, or START if key caching hits.
- KEY_LOAD: `core_key_init`=1 for one cycle, then KEY_WAIT.
- KEY_WAIT: ignore `core_key_ready` for the first 2 cycles (blanking). Then go to START when `core_key_ready`=1.
- START: `core_next`=1 for one cycle, then WAIT_CLR.
- WAIT_CLR: wait for `core_block_ready`=0, which rejects the stale done flag from the previous block. Then WAIT_DONE.
- WAIT_DONE: on `core_block_ready`=1, register `core_output_block` into `rsp_block` and go to RESP.
- RESP: `rsp_valid`=1 and held stable until `rsp_ready`. Then return to IDLE.
- Watchdog: counter cleared on entering KEY_WAIT and WAIT_CLR. It counts in KEY_WAIT/WAIT_CLR/WAIT_DONE. When it reaches TIMEOUT_CYCLES: go to RESP with `rsp_err`=1 and invalidate the cached key.
- Requesters deasserting `req_valid` before grant is permitted; no state is kept for them.

## Timing
- Reset: state IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_block`=0, `rsp_err`=0, `core_key`=0, `core_key_init`=0, `core_next`=0, `core_input_block`=0, key cache invalid.
- Overhead outside core time: accept→key_init is 1 cycle, START→next is 1 cycle, done→`rsp_valid` is 1 cycle.
- Back-to-back: a new grant is possible in the cycle after the RESP handshake. There is no overlap of jobs.
- Reset mid-job: everything returns to reset values immediately. The core shares `aresetn`, so no cleanup sequence is needed.
- Single requester: it is granted every time; round-robin never starves any requester (max wait NUM_REQ-1 jobs).

## Configuration
- `AES_ARB_KEY_CACHE_EN` defined: keep the last loaded key and a valid bit. If the granted key equals the cached key and the cache is valid, skip KEY_LOAD/KEY_WAIT and go straight to START. The cache is invalidated on reset and on timeout.
- Undefined: every job runs KEY_LOAD and KEY_WAIT.

## Structure
- Package `aes_pkg`: `AES_KEY_W`=128, `AES_BLK_W`=128, FSM state enum `aes_arb_state_t`, and a default timeout constant.
- Sub-module `aes_rr_arbiter`: parameterised round-robin pick (request vector + last_grant → one-hot grant + index), purely combinational.
- The top instantiates the arbiter and the FSM/datapath registers. It does not instantiate the AES core; the core connects at the integration level.

## Test plan
- Single job, FIPS-197 key 000102…0f, plaintext 00112233…eeff → `rsp_block`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_id`=0, `rsp_err`=0.
- All 4 `req_valid` held high with distinct keys → grants and `rsp_id` sequence 0,1,2,3,0; no requester granted twice before the others.
- `rsp_ready` held low for 20 cycles after `rsp_valid` → `rsp_valid`/`rsp_block` stable, all `req_ready`=0, no `core_next` pulse.
- Two jobs, same key (with `AES_ARB_KEY_CACHE_EN`) → exactly one `core_key_init` pulse. Without the macro → two pulses. Both runs give correct ciphertext.
- Core stub that never raises `core_block_ready`, TIMEOUT_CYCLES=16 → RESP reached 16 cycles after entering WAIT_CLR with `rsp_err`=1, `rsp_block`=0; the next job reloads the key.
- `aresetn` pulsed low during WAIT_DONE → all outputs return to reset values asynchronously; after release the first grant goes to requester 0.
